jtkcpu_stack_seq: RTL and testbench
===================================

# jtkcpu_stack_seq

Stack transfer sequencer for the KCPU core. It walks a PSHS/PSHU/PULS/PULU postbyte one byte at a time and drives the register file's stack controls (`psh_sel`, `psh_hihalf`, `psh_dec`, `pul_en`, `stack_busy`, `psh_ussel`). It also issues the matching memory byte cycles. It is the initiator side of the register file's push/pull interface: it sends the bytes the register file supplies, and fetches the bytes the register file absorbs.

## Interface
No parameters.
- rst  in  1  asynchronous reset, active high
- clk  in  1  clock
- cen  in  1  clock enable; all state advances only on cen
- psh_go  in  1  start a push; sampled in IDLE only
- pul_go  in  1  start a pull; sampled in IDLE only, psh_go has priority
- postbyte  in  8  register mask: b7 PC, b6 other SP, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
- ussel  in  1  1 = U stack, 0 = S stack; latched at start
- stack_bit  in  8  one-hot of the register currently selected, from the register file
- psh_mux  in  8  byte to push, from the register file
- psh_addr  in  16  current stack pointer value, from the register file
- psh_sel  out  8  remaining register mask
- psh_hihalf  out  1  selects the high byte of a 16-bit register
- psh_ussel  out  1  latched ussel
- psh_dec  out  1  decrement stack pointer this cen
- pul_en  out  1  pull in progress
- stack_busy  out  1  sequencer active
- addr  out  16  memory byte address
- dout  out  8  memory write data
- we  out  1  memory write strobe, one cen
- rd  out  1  memory read strobe, one cen; data returns on mdata at the next cen
- done  out  1  single-cen pulse at the end of a transfer

## Operation
- States: IDLE, PSH_DEC, PSH_WR, PUL_RD, FIN.
- 16-bit registers are mask bits 7..4; 8-bit registers are bits 3..0.
- IDLE, on psh_go:
  - psh_sel<=postbyte, psh_ussel<=ussel, hihalf<=0.
  - Go to PSH_DEC, or to FIN if postbyte==0.
- IDLE, on pul_go: same latching, hihalf<=1, go to PUL_RD, or to FIN if postbyte==0.
- Push order is highest mask bit first. A 16-bit register pushes its low byte first, then its high byte.
  - PSH_DEC: psh_dec=1; the register file decrements the selected SP. Next state PSH_WR.
  - PSH_WR: we=1, addr=psh_addr, dout=psh_mux.
  - After PSH_WR, for an 8-bit register or when hihalf=1: psh_sel<=psh_sel&~stack_bit and hihalf<=0. Otherwise hihalf<=1.
  - Next state is PSH_DEC if the new psh_sel!=0, else FIN.
- Pull order is lowest mask bit first (CC first). A 16-bit register pulls its high byte first.
  - PUL_RD: rd=1, addr=psh_addr, pul_en=1. The register file increments the SP because psh_sel!=0 and stack_busy=1.
  - Mask update is the same as for push, except hihalf returns to 1 at each new register. hihalf toggles 1→0 within a 16-bit register.
  - Stay in PUL_RD while the new psh_sel!=0, else go to FIN.
- psh_hihalf output:
  - During a push it equals hihalf.
  - During a pull and in the FIN after a pull it equals hihalf delayed one cen, so it matches the byte present on mdata when the register file applies it.
- FIN: stack_busy=1, psh_sel==0, pul_en held if pulling so the last pulled byte is applied. Assert done, then go to IDLE.
- stack_busy=1 in every state except IDLE. psh_go/pul_go are ignored while busy.
- Memory addresses are the 16-bit SP value as provided; wrap at 0x0000/0xFFFF is the register file's modular arithmetic, not checked here.

## Timing
- Reset values: all outputs 0, state IDLE, hihalf 0.
- All outputs are registered except addr, dout, we, rd, psh_dec, which decode from state and inputs.
- Push: 2 cen per byte plus 1 FIN cen. Pull: 1 cen per byte plus 1 FIN cen.
- Start is accepted on the cen where IDLE samples go; the first access happens on the following cen.
- cen low freezes every state and output.
- Reset mid-transfer returns to IDLE immediately. SP changes already made are kept; no done pulse.
- Postbyte 0: IDLE→FIN→IDLE with one busy cen, no memory access, done pulses.

## Test plan
- Push PC only: postbyte=0x80, ussel=0, S=0x1000, PC=0x1234 → 0x34 written at 0x0FFF, then 0x12 at 0x0FFE; S=0x0FFE; done 5 cen after start.
- Pull A,B,CC: postbyte=0x07, S=0x0FFD, memory 0x0FFD..0x0FFF=0x11,0x22,0x33 → CC=0x11, A=0x22, B=0x33; S=0x1000; done 4 cen after start.
- Full push then pull: postbyte=0xFF, ussel=1, U=0x2000 → 12 bytes written at 0x1FF4..0x1FFF. Pulling back restores every register and U=0x2000; psh_hihalf matches each 16-bit byte.
- cen toggled 1-of-3 during a push of 0x30 → identical memory image and register state as with cen=1.
- Postbyte 0 push and pull → no we/rd, one busy cen, done pulse.
- rst asserted in the middle of the X push → all outputs 0 on the same edge; a new psh_go is accepted normally afterwards.

Source files
------------

// File: rtl/jtkcpu_stack_seq.sv
// jtkcpu_stack_seq
// Stack transfer sequencer for the KCPU core. Walks a PSHS/PSHU/PULS/PULU
// postbyte one byte at a time, drives the register file's push/pull controls
// and issues the matching memory byte cycles.
//
// Ports
//   rst         async reset, active high
//   clk         clock
//   cen         clock enable; nothing advances while low
//   psh_go      start a push (sampled in IDLE)
//   pul_go      start a pull (sampled in IDLE, psh_go wins)
//   postbyte    register mask: b7 PC, b6 other SP, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
//   ussel       1 = U stack, 0 = S stack, latched at start
//   stack_bit   one-hot of the register the register file has selected
//   psh_mux     byte offered by the register file for a push
//   psh_addr    current stack pointer value from the register file
//   psh_sel     remaining register mask
//   psh_hihalf  high-byte select for 16-bit registers
//   psh_ussel   latched ussel
//   psh_dec     register file decrements the selected SP this cen
//   pul_en      pull in progress
//   stack_busy  sequencer active
//   addr        memory byte address
//   dout        memory write data
//   we          memory write strobe
//   rd          memory read strobe; data comes back on the next cen
//   done        single-cen pulse at the end of a transfer
module jtkcpu_stack_seq (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        psh_go,
    input  logic        pul_go,
    input  logic [7:0]  postbyte,
    input  logic        ussel,
    input  logic [7:0]  stack_bit,
    input  logic [7:0]  psh_mux,
    input  logic [15:0] psh_addr,
    output logic [7:0]  psh_sel,
    output logic        psh_hihalf,
    output logic        psh_ussel,
    output logic        psh_dec,
    output logic        pul_en,
    output logic        stack_busy,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        rd,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PSH_DEC = 3'd1,
        PSH_WR  = 3'd2,
        PUL_RD  = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t      state, state_nx;
    logic        hihalf, hihalf_nx;
    logic [7:0]  sel_nx;
    logic        ussel_nx;
    logic        is16;

    // Mask bits 7..4 are the 16-bit registers.
    assign is16 = |stack_bit[7:4];

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_nx  = state;
        hihalf_nx = hihalf;
        sel_nx    = psh_sel;
        ussel_nx  = psh_ussel;
        psh_dec   = 1'b0;
        we        = 1'b0;
        rd        = 1'b0;
        addr      = 16'h0000;
        dout      = 8'h00;

        case (state)
            IDLE: begin
                if (psh_go) begin
                    sel_nx    = postbyte;
                    ussel_nx  = ussel;
                    hihalf_nx = 1'b0;
                    state_nx  = (postbyte == 8'h00) ? FIN : PSH_DEC;
                end else if (pul_go) begin
                    sel_nx    = postbyte;
                    ussel_nx  = ussel;
                    hihalf_nx = 1'b1;
                    state_nx  = (postbyte == 8'h00) ? FIN : PUL_RD;
                end
            end
            PSH_DEC: begin
                psh_dec  = 1'b1;
                state_nx = PSH_WR;
            end
            PSH_WR: begin
                we   = 1'b1;
                addr = psh_addr;
                dout = psh_mux;
                // Push goes low byte then high byte.
                if (!is16 || hihalf) begin
                    sel_nx    = psh_sel & ~stack_bit;
                    hihalf_nx = 1'b0;
                end else begin
                    hihalf_nx = 1'b1;
                end
                state_nx = (sel_nx != 8'h00) ? PSH_DEC : FIN;
            end
            PUL_RD: begin
                rd   = 1'b1;
                addr = psh_addr;
                // Pull goes high byte then low byte.
                if (!is16 || !hihalf) begin
                    sel_nx    = psh_sel & ~stack_bit;
                    hihalf_nx = 1'b1;
                end else begin
                    hihalf_nx = 1'b0;
                end
                state_nx = (sel_nx != 8'h00) ? PUL_RD : FIN;
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: reset is asynchronous and active high so a mid-transfer reset
    // clears every registered output on the same edge it is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            hihalf     <= 1'b0;
            psh_sel    <= 8'h00;
            psh_ussel  <= 1'b0;
            psh_hihalf <= 1'b0;
            pul_en     <= 1'b0;
            stack_busy <= 1'b0;
            done       <= 1'b0;
        end else if (cen) begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, independent of statement order.
            state      <= state_nx;
            hihalf     <= hihalf_nx;
            psh_sel    <= sel_nx;
            psh_ussel  <= ussel_nx;
            stack_busy <= (state_nx != IDLE);
            done       <= (state_nx == FIN);
            // The last pulled byte is applied during FIN, so keep pul_en up.
            pul_en     <= (state_nx == PUL_RD) ||
                          (state_nx == FIN && state == PUL_RD);
            // While pulling, the half flag lags one cen so it lines up with
            // the byte arriving on the memory data bus.
            psh_hihalf <= (state_nx == PUL_RD || state == PUL_RD) ? hihalf
                                                                  : hihalf_nx;
        end
    end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Testbench for jtkcpu_stack_seq. Surrounds the sequencer with a small
// register file and byte memory, and checks each transfer against expected
// stack images computed from the push/pull ordering rules.
module tb_jtkcpu_stack_seq;

    logic        rst, clk, cen, psh_go, pul_go, ussel;
    logic [7:0]  postbyte, stack_bit, psh_mux, psh_sel, dout;
    logic [15:0] psh_addr, addr;
    logic        psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy, we, rd, done;

    jtkcpu_stack_seq dut (
        .rst(rst), .clk(clk), .cen(cen), .psh_go(psh_go), .pul_go(pul_go),
        .postbyte(postbyte), .ussel(ussel), .stack_bit(stack_bit),
        .psh_mux(psh_mux), .psh_addr(psh_addr), .psh_sel(psh_sel),
        .psh_hihalf(psh_hihalf), .psh_ussel(psh_ussel), .psh_dec(psh_dec),
        .pul_en(pul_en), .stack_busy(stack_busy), .addr(addr), .dout(dout),
        .we(we), .rd(rd), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: register file (r[6] unused, bit 6 is the other SP) and memory
    logic [15:0] r   [0:7];
    logic [15:0] sp  [0:1];
    logic [7:0]  mem [0:65535];
    logic [7:0]  mdata, bit_d;
    logic        rd_d;
    logic [15:0] sel_val;

    // Host-side setup writes into the environment, one per clock.
    logic        set_req;
    int          set_kind, set_idx;
    logic [15:0] set_val;

    always_comb begin
        stack_bit = 8'h00;
        if (pul_en) begin
            for (int i = 7; i >= 0; i--) if (psh_sel[i]) stack_bit = 8'(1 << i);
        end else begin
            for (int i = 0; i < 8; i++) if (psh_sel[i]) stack_bit = 8'(1 << i);
        end
    end

    always_comb begin
        sel_val = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (stack_bit[i]) sel_val = (i == 6) ? sp[!psh_ussel] : r[i];
        psh_mux = psh_hihalf ? sel_val[15:8] : sel_val[7:0];
    end

    assign psh_addr = sp[psh_ussel];

    always @(posedge clk) begin
        if (set_req) begin
            case (set_kind)
                0:       r[set_idx]         <= set_val;
                1:       sp[set_idx]        <= set_val;
                default: mem[set_idx[15:0]] <= set_val[7:0];
            endcase
        end
        if (rst) begin
            rd_d <= 1'b0;
        end else if (cen) begin
            if (psh_dec) sp[psh_ussel] <= sp[psh_ussel] - 16'd1;
            if (pul_en && stack_busy && psh_sel != 8'h00) sp[psh_ussel] <= sp[psh_ussel] + 16'd1;
            if (we) mem[addr] <= dout;
            if (rd) mdata <= mem[addr];
            rd_d  <= rd;
            bit_d <= stack_bit;
            if (rd_d) begin
                for (int i = 0; i < 8; i++) begin
                    if (bit_d[i]) begin
                        if (i == 6)
                            sp[!psh_ussel] <= psh_hihalf ? {mdata, sp[!psh_ussel][7:0]}
                                                         : {sp[!psh_ussel][15:8], mdata};
                        else if (i >= 4)
                            r[i] <= psh_hihalf ? {mdata, r[i][7:0]} : {r[i][15:8], mdata};
                        else
                            r[i] <= {8'h00, mdata};
                    end
                end
            end
        end
    end

    // Checking infrastructure
    int total, bad;
    bit cen_div;
    int ph;
    logic [15:0] orig [0:7];
    logic [7:0]  img  [0:3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cen();
        if (cen_div) begin
            cen = (ph == 0);
            ph  = (ph == 2) ? 0 : ph + 1;
        end else begin
            cen = 1'b1;
        end
    endtask

    task automatic poke(input int kind, input int idx, input logic [15:0] val);
        @(negedge clk);
        set_kind = kind; set_idx = idx; set_val = val; set_req = 1'b1;
        @(posedge clk);
        #1 set_req = 1'b0;
    endtask

    task automatic rand_regs(input bit us);
        for (int b = 0; b < 8; b++) begin
            if (b != 6) poke(0, b, (b < 4) ? 16'($urandom_range(0, 255)) : 16'($urandom));
        end
        poke(1, int'(!us), 16'($urandom));
    endtask

    task automatic snap(input bit us);
        for (int b = 0; b < 8; b++) orig[b] = (b == 6) ? sp[!us] : r[b];
    endtask

    task automatic launch(input bit pull, input logic [7:0] pb, input bit us);
        do begin
            @(negedge clk);
            next_cen();
        end while (!cen);
        psh_go = !pull; pul_go = pull; postbyte = pb; ussel = us;
        @(negedge clk);
        psh_go = 1'b0; pul_go = 1'b0;
        postbyte = 8'($urandom); ussel = 1'($urandom);
    endtask

    // Counts cen edges until done shows up, then steps through the FIN cen.
    task automatic wait_done(output int ncen, output int nwe, output int nrd);
        int  edges;
        bit  got, was;
        edges = 0; nwe = 0; nrd = 0; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            next_cen();
            if (cen) begin
                edges++;
                if (we) nwe++;
                if (rd) nrd++;
            end
            @(negedge clk);
        end
        check("done seen", 32'(got), 32'd1);
        ncen = edges + 1;
        do begin
            next_cen();
            was = cen;
            @(negedge clk);
        end while (!was);
        check("done single pulse", 32'(done), 32'd0);
        check("idle after fin", {stack_busy, psh_sel}, 32'd0);
    endtask

    task automatic do_push(input logic [7:0] pb, input bit us);
        logic [15:0] val [0:7];
        logic [15:0] a;
        logic [15:0] ea [$];
        logic [7:0]  ed [$];
        int ncen, nwe, nrd;
        for (int b = 0; b < 8; b++) val[b] = (b == 6) ? sp[!us] : r[b];
        a = sp[us];
        for (int b = 7; b >= 0; b--) begin
            if (pb[b]) begin
                a = a - 16'd1; ea.push_back(a); ed.push_back(val[b][7:0]);
                if (b >= 4) begin
                    a = a - 16'd1; ea.push_back(a); ed.push_back(val[b][15:8]);
                end
            end
        end
        launch(1'b0, pb, us);
        wait_done(ncen, nwe, nrd);
        check("push cens", ncen, 2 * ea.size() + 1);
        check("push writes", nwe, ea.size());
        check("push reads", nrd, 0);
        check("push sp", {16'h0, sp[us]}, {16'h0, a});
        check("push ussel", 32'(psh_ussel), 32'(us));
        for (int j = 0; j < ea.size(); j++)
            check("push byte", {24'h0, mem[ea[j]]}, {24'h0, ed[j]});
    endtask

    task automatic do_pull(input logic [7:0] pb, input bit us);
        logic [15:0] expv [0:7];
        logic [15:0] a;
        int n, ncen, nwe, nrd;
        n = 0;
        for (int b = 0; b < 8; b++) expv[b] = (b == 6) ? sp[!us] : r[b];
        a = sp[us];
        for (int b = 0; b < 8; b++) begin
            if (pb[b]) begin
                if (b >= 4) begin
                    expv[b][15:8] = mem[a]; a = a + 16'd1;
                    expv[b][7:0]  = mem[a]; a = a + 16'd1;
                    n += 2;
                end else begin
                    expv[b] = {8'h00, mem[a]}; a = a + 16'd1;
                    n += 1;
                end
            end
        end
        launch(1'b1, pb, us);
        wait_done(ncen, nwe, nrd);
        check("pull cens", ncen, n + 1);
        check("pull reads", nrd, n);
        check("pull writes", nwe, 0);
        check("pull sp", {16'h0, sp[us]}, {16'h0, a});
        for (int b = 0; b < 8; b++)
            check("pull reg", {16'h0, (b == 6) ? sp[!us] : r[b]}, {16'h0, expv[b]});
    endtask

    initial begin
        logic [7:0]  pb;
        bit          us;
        total = 0; bad = 0; cen_div = 1'b0; ph = 0;
        rst = 1'b1; cen = 1'b1; psh_go = 1'b0; pul_go = 1'b0;
        postbyte = 8'h00; ussel = 1'b0; set_req = 1'b0;
        set_kind = 0; set_idx = 0; set_val = 16'h0;
        for (int b = 0; b < 8; b++) poke(0, b, 16'h0000);
        poke(1, 0, 16'h0000);
        poke(1, 1, 16'h0000);
        check("reset flags", {psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en,
                              stack_busy, we, rd, done}, 32'd0);
        check("reset bus", {addr, dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Push PC only onto S
        poke(0, 7, 16'h1234);
        poke(1, 0, 16'h1000);
        do_push(8'h80, 1'b0);
        check("pc low byte", {24'h0, mem[16'h0FFF]}, 32'h34);
        check("pc high byte", {24'h0, mem[16'h0FFE]}, 32'h12);
        check("s after pc push", {16'h0, sp[0]}, 32'h0FFE);

        // Pull A, B, CC from S
        poke(2, 16'h0FFD, 16'h0011);
        poke(2, 16'h0FFE, 16'h0022);
        poke(2, 16'h0FFF, 16'h0033);
        poke(1, 0, 16'h0FFD);
        do_pull(8'h07, 1'b0);
        check("cc pulled", {16'h0, r[0]}, 32'h11);
        check("a pulled", {16'h0, r[1]}, 32'h22);
        check("b pulled", {16'h0, r[2]}, 32'h33);
        check("s after pull", {16'h0, sp[0]}, 32'h1000);

        // Full push then pull on U
        rand_regs(1'b1);
        poke(1, 1, 16'h2000);
        snap(1'b1);
        do_push(8'hFF, 1'b1);
        check("u after full push", {16'h0, sp[1]}, 32'h1FF4);
        rand_regs(1'b1);
        do_pull(8'hFF, 1'b1);
        for (int b = 0; b < 8; b++)
            check("full restore", {16'h0, (b == 6) ? sp[0] : r[b]}, {16'h0, orig[b]});
        check("u after full pull", {16'h0, sp[1]}, 32'h2000);

        // Y,X push with cen always high, then with cen 1-of-3
        poke(0, 5, 16'($urandom));
        poke(0, 4, 16'($urandom));
        poke(1, 0, 16'h3000);
        snap(1'b0);
        do_push(8'h30, 1'b0);
        for (int j = 0; j < 4; j++) img[j] = mem[16'h2FFC + 16'(j)];
        poke(1, 0, 16'h3000);
        for (int j = 0; j < 4; j++) poke(2, 16'h2FFC + j, 16'h0000);
        cen_div = 1'b1;
        do_push(8'h30, 1'b0);
        for (int j = 0; j < 4; j++)
            check("cen gated image", {24'h0, mem[16'h2FFC + 16'(j)]}, {24'h0, img[j]});
        check("cen gated sp", {16'h0, sp[0]}, 32'h2FFC);
        rand_regs(1'b0);
        do_pull(8'h30, 1'b0);
        check("cen gated y", {16'h0, r[5]}, {16'h0, orig[5]});
        check("cen gated x", {16'h0, r[4]}, {16'h0, orig[4]});
        cen_div = 1'b0;

        // Empty postbyte: one busy cen, no memory access
        do_push(8'h00, 1'b0);
        do_pull(8'h00, 1'b1);

        // Reset in the middle of an X push on U
        poke(0, 4, 16'hBEEF);
        poke(1, 1, 16'h4000);
        launch(1'b0, 8'h10, 1'b1);
        next_cen();
        @(negedge clk);
        check("mid push we", 32'(we), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid reset flags", {psh_sel, psh_hihalf, psh_ussel, psh_dec, pul_en,
                                  stack_busy, we, rd, done}, 32'd0);
        check("mid reset bus", {addr, dout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("sp kept after reset", {16'h0, sp[1]}, 32'h3FFF);
        do_push(8'h10, 1'b1);
        check("x low after reset", {24'h0, mem[16'h3FFE]}, 32'hEF);
        check("x high after reset", {24'h0, mem[16'h3FFD]}, 32'hBE);

        // Randomized push/pull round trips
        for (int it = 0; it < 15; it++) begin
            us      = 1'($urandom);
            pb      = 8'($urandom_range(1, 255));
            cen_div = 1'($urandom);
            rand_regs(us);
            poke(1, int'(us), 16'($urandom_range(16'h0100, 16'hFF00)));
            snap(us);
            do_push(pb, us);
            rand_regs(us);
            do_pull(pb, us);
            for (int b = 0; b < 8; b++)
                if (pb[b])
                    check("round trip", {16'h0, (b == 6) ? sp[!us] : r[b]}, {16'h0, orig[b]});
        end
        cen_div = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
